// File: rtl/morse_pkg.sv
// Shared constants, state encoding and the ITU lookup table for the Morse decoder.
// Element bits are right-aligned with the first element in the MSB of the used field, dash=1.
package morse_pkg;

  localparam logic [1:0] SYM_DOT      = 2'b01;
  localparam logic [1:0] SYM_DASH     = 2'b11;
  localparam logic [1:0] SYM_END_CHAR = 2'b00;
  localparam logic [1:0] SYM_END_WORD = 2'b10;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    ACC   = 1'b0,
    SPACE = 1'b1
  } state_t;

  // Returns {hit, ascii}; any length/pattern outside the table is a miss.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [5:0] bits);
    logic [7:0] c;
    c = 8'h00;
    case (len)
      3'd1: c = bits[0] ? "T" : "E";
      3'd2:
        case (bits[1:0])
          2'b00:   c = "I";
          2'b01:   c = "A";
          2'b10:   c = "N";
          default: c = "M";
        endcase
      3'd3:
        case (bits[2:0])
          3'b000:  c = "S";
          3'b001:  c = "U";
          3'b010:  c = "R";
          3'b011:  c = "W";
          3'b100:  c = "D";
          3'b101:  c = "K";
          3'b110:  c = "G";
          default: c = "O";
        endcase
      3'd4:
        case (bits[3:0])
          4'b0000: c = "H";
          4'b0001: c = "V";
          4'b0010: c = "F";
          4'b0100: c = "L";
          4'b0110: c = "P";
          4'b0111: c = "J";
          4'b1000: c = "B";
          4'b1001: c = "X";
          4'b1010: c = "C";
          4'b1011: c = "Y";
          4'b1100: c = "Z";
          4'b1101: c = "Q";
          default: c = 8'h00;
        endcase
      3'd5:
        case (bits[4:0])
          5'b11111: c = "0";
          5'b01111: c = "1";
          5'b00111: c = "2";
          5'b00011: c = "3";
          5'b00001: c = "4";
          5'b00000: c = "5";
          5'b10000: c = "6";
          5'b11000: c = "7";
          5'b11100: c = "8";
          5'b11110: c = "9";
          default:  c = 8'h00;
        endcase
      default: c = 8'h00;
    endcase
    if (bits[5]) c = 8'h00;
    return {(c != 8'h00), c};
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Show-ahead character FIFO with occupancy output; head reads as 8'h00 when empty.
module morse_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic                   valid,
  output logic                   full,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign valid = (level != '0);
  assign full  = level[PTR_W];
  assign rd_en = pop && valid;
  assign wr_en = push && (!full || rd_en);
  assign dout  = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      level <= level + 1'b1;
      else if (rd_en && !wr_en) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/morse_decoder_buf.sv
// Morse element stream decoder: accumulates elements, decodes to ASCII, collapses word
// spaces, buffers characters in a FIFO and keeps running character/error counters.
module morse_decoder_buf
  import morse_pkg::*;
#(
  parameter int         MAX_SYMS   = 5,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CNT_W      = 12,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sym_valid,
  input  logic [1:0]                  sym,
  output logic                        sym_ready,
  output logic                        chr_valid,
  output logic [7:0]                  chr_data,
  input  logic                        chr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            char_count,
  output logic [CNT_W-1:0]            err_count,
  output logic                        overflow
);

  state_t              state, state_next;
  logic [MAX_SYMS-1:0] acc_bits, acc_bits_next;
  logic [2:0]          acc_len, acc_len_next;
  logic                overlong, overlong_next;
  logic                last_was_space, last_was_space_next;
  logic                push, push_char, push_err;
  logic [7:0]          push_data;
  logic                full, pop, accept, dec_err;
  logic [8:0]          look;
  logic [7:0]          decoded;

  assign sym_ready = rst_n && (state == ACC) && !full;
  assign accept    = sym_valid && sym_ready;
  assign pop       = chr_valid && chr_ready;
  assign look      = morse_lookup(acc_len, 6'(acc_bits));
  assign dec_err   = overlong || !look[8];
  assign decoded   = dec_err ? ERR_CHAR : look[7:0];

  always_comb begin
    state_next          = state;
    acc_bits_next       = acc_bits;
    acc_len_next        = acc_len;
    overlong_next       = overlong;
    last_was_space_next = last_was_space;
    push                = 1'b0;
    push_char           = 1'b0;
    push_err            = 1'b0;
    push_data           = ASCII_SPACE;
    case (state)
      ACC: begin
        if (accept) begin
          case (sym)
            SYM_DOT, SYM_DASH: begin
              if (acc_len < 3'(MAX_SYMS)) begin
                acc_bits_next = {acc_bits[MAX_SYMS-2:0], sym[1]};
                acc_len_next  = acc_len + 3'd1;
              end else begin
                overlong_next = 1'b1;
              end
            end
            default: begin
              // END_CHAR and END_WORD both flush a pending character first.
              if (acc_len != 3'd0) begin
                push                = 1'b1;
                push_char           = 1'b1;
                push_err            = dec_err;
                push_data           = decoded;
                acc_bits_next       = '0;
                acc_len_next        = 3'd0;
                overlong_next       = 1'b0;
                last_was_space_next = 1'b0;
                if (sym == SYM_END_WORD) state_next = SPACE;
              end else if ((sym == SYM_END_WORD) && !last_was_space) begin
                push                = 1'b1;
                last_was_space_next = 1'b1;
              end
            end
          endcase
        end
      end
      SPACE: begin
        if (!full) begin
          push                = 1'b1;
          last_was_space_next = 1'b1;
          state_next          = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ACC;
      acc_bits       <= '0;
      acc_len        <= 3'd0;
      overlong       <= 1'b0;
      last_was_space <= 1'b1;
      char_count     <= '0;
      err_count      <= '0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_next;
      acc_bits       <= acc_bits_next;
      acc_len        <= acc_len_next;
      overlong       <= overlong_next;
      last_was_space <= last_was_space_next;
      if (push && push_char) char_count <= char_count + CNT_W'(1);
      if (push && push_err)  err_count  <= err_count + CNT_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  morse_char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .valid (chr_valid),
    .full  (full),
    .dout  (chr_data),
    .level (fifo_level)
  );

endmodule

// File: doc/morse_decoder_buf.md
Name: morse_decoder_buf

Overview:
Parametrised successor to the Morse decoder. Accepts a stream of 2-bit Morse element codes over a valid/ready handshake and decodes them into ASCII. Supported characters are A–Z, 0–9, a word-space and an error character. Decoded characters are buffered in an internal FIFO and drained through a valid/ready output port. The block sits between the key/element front-end and the display/UART consumer, and carries running character and error counters.

Parameters:
MAX_SYMS, 5, maximum elements per character; legal range 4..6.
FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
CNT_W, 12, width of char_count and err_count.
ERR_CHAR, 8'h3F, ASCII byte emitted for an undecodable character ('?').

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
sym_valid  in  1  sym holds a valid element code
sym  in  2  element code: 01 DOT, 11 DASH, 00 END_CHAR, 10 END_WORD
sym_ready  out  1  block accepts sym this cycle
chr_valid  out  1  chr_data valid (FIFO not empty)
chr_data  out  8  ASCII character at the FIFO head
chr_ready  in  1  consumer pops the FIFO head
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO
char_count  out  CNT_W  non-space characters pushed, including ERR_CHAR; wraps modulo 2^CNT_W
err_count  out  CNT_W  ERR_CHAR pushes; wraps
overflow  out  1  sticky; set if a push is attempted while the FIFO is full (must never happen; assertion target)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state ACC; accumulator length 0; overlong flag 0; last_was_space 1.
  - FIFO empty.
  - chr_valid 0, chr_data 8'h00, fifo_level 0, counts 0, overflow 0, sym_ready 0 while reset is asserted.
- Accumulator: element bits shift register (dash=1, first element in MSB of the used field) plus a length counter 0..MAX_SYMS.
- A symbol is accepted on a clock edge where sym_valid && sym_ready. sym_ready = (state==ACC) && (fifo_level < FIFO_DEPTH).
- DOT/DASH handling:
  - If len < MAX_SYMS: append the element and increment len.
  - Otherwise: set overlong; len saturates.
- END_CHAR handling:
  - len==0: no-op, no push.
  - Otherwise: push lookup(len, bits), or ERR_CHAR if there is no match or overlong is set.
  - Clear the accumulator and set last_was_space=0.
- END_WORD handling:
  - len>0: push the decoded character this cycle (same rules as END_CHAR), then go to state SPACE.
  - len==0 and last_was_space==0: push 8'h20, set last_was_space=1.
  - Otherwise: no-op. Leading and repeated spaces are collapsed.
- State SPACE: sym_ready=0. Push 8'h20 on the first cycle the FIFO is not full, set last_was_space=1, return to ACC.
- Latency: a char pushed on edge N is visible at chr_data/chr_valid after edge N (registered FIFO, show-ahead head).
- FIFO:
  - Pop when chr_valid && chr_ready.
  - Simultaneous push and pop: both take effect and level is unchanged. This is legal when full only if pop occurs, but sym_ready already blocks pushes when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters: char_count increments on every non-space push; err_count increments on every ERR_CHAR push. Both wrap without saturation.
- Lookup: ITU table.
  - A=.-, B=-..., C=-.-., D=-.., E=., F=..-., G=--., H=...., I=.., J=.---, K=-.-, L=.-.., M=--, N=-., O=---, P=.--., Q=--.-, R=.-., S=..., T=-, U=..-, V=...-, W=.--, X=-..-, Y=-.--, Z=--..
  - Digits 0..9 use the 5-element codes.
  - Any other (len, bits) combination maps to ERR_CHAR.
- Reset mid-character or mid-SPACE discards the partial character and all FIFO contents.

Decomposition:
- Shared package morse_pkg:
  - element code constants SYM_DOT/SYM_DASH/SYM_END_CHAR/SYM_END_WORD
  - state encodings ACC/SPACE
  - ASCII_SPACE
  - function morse_lookup(len, bits) returning {hit, ascii}
- One sub-module, morse_char_fifo: parametrised FIFO_DEPTH×8 show-ahead FIFO with level output. The decoder top holds the accumulator, FSM and counters.

Test Plan:
- "UMUT OZTURK" stream (..- 00 -- 00 ..- 00 - 00 10 --- 00 --.. 00 - 00 ..- 00 .-. 00 -.- 00), chr_ready=1 -> chr_data sequence "UMUT OZTURK", char_count=10, err_count=0, overflow=0.
- Six DOTs then END_CHAR -> one ERR_CHAR (8'h3F); err_count=1; char_count=1. The next ". 00" decodes 'E'.
- chr_ready=0, nine "E" characters -> sym_ready drops once fifo_level=8. Raising chr_ready then yields exactly nine 'E' in order, with no overflow.
- "-----" 00 ".----" 00 "..---" 10 -> "012 ", with the space pushed one cycle after '2' and sym_ready low during SPACE.
- Stream 10 10 00 . 10 10 10 -> only "E " (leading and repeated spaces suppressed, empty END_CHAR ignored).
- Assert rst_n low after "-.-" without END_CHAR and with 3 chars buffered -> chr_valid=0, fifo_level=0 and counts=0 immediately. A following ". 00" outputs 'E', not a corrupted code.
